// File: rtl/unipolar_rz_decoder.sv
// Unipolar RZ line decoder.
// Samples an asynchronous RZ line and measures each high pulse. A pulse of
// THRESHOLD_TIME or longer decodes as 1, and a shorter one decodes as 0.
// Bits are packed LSB-first into DATA_WIDTH-bit words. A long low ends a frame.
// Glitches, over-long highs and truncated words are flagged on error.
module unipolar_rz_decoder #(
    parameter int  DATA_WIDTH     = 24,
    parameter real CLOCK_RATE     = 50e6,
    parameter real MIN_HIGH_TIME  = 0.1e-6,
    parameter real THRESHOLD_TIME = 0.6e-6,
    parameter real MAX_HIGH_TIME  = 1.5e-6,
    parameter real RESET_TIME     = 50e-6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  line,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  frame_end,
    output logic                  error,
    output logic                  synced
);

    // Cycle counts derived from the timing parameters, rounded like the encoder.
    localparam int MIN_CYC = int'(CLOCK_RATE * MIN_HIGH_TIME);
    localparam int THR_CYC = int'(CLOCK_RATE * THRESHOLD_TIME);
    localparam int MAX_CYC = int'(CLOCK_RATE * MAX_HIGH_TIME);
    localparam int RST_CYC = int'(CLOCK_RATE * RESET_TIME);
    localparam int RST_M1  = RST_CYC - 1;
    localparam int LAST_BIT = DATA_WIDTH - 1;

    localparam int CW = $clog2(RST_CYC + 2);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] MIN_W    = MIN_CYC[CW-1:0];
    localparam logic [CW-1:0] THR_W    = THR_CYC[CW-1:0];
    localparam logic [CW-1:0] MAX_W    = MAX_CYC[CW-1:0];
    localparam logic [CW-1:0] RST_W    = RST_CYC[CW-1:0];
    localparam logic [CW-1:0] RST_M1_W = RST_M1[CW-1:0];
    localparam logic [BW-1:0] LAST_W   = LAST_BIT[BW-1:0];

    typedef enum logic [1:0] {
        WAIT_RESET,
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t                state, state_nx;
    logic                  line_meta, line_s, line_d;
    logic [CW-1:0]         counter;
    logic [BW-1:0]         bit_count, bit_count_nx;
    logic [DATA_WIDTH-1:0] shift_reg, shift_nx;
    logic [DATA_WIDTH-1:0] data_nx;
    logic                  word_seen, word_seen_nx;
    logic                  valid_nx, error_nx, frame_end_nx;

    logic rise, fall;
    logic low_done, high_timeout, width_ok, bit_val;

    // Two-flop synchronizer for the asynchronous line, plus a one-cycle delayed copy for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_meta <= 1'b0;
            line_s    <= 1'b0;
            line_d    <= 1'b0;
        end else begin
            // NOTE: registers use <= so every flop samples pre-edge values; blocking here would collapse the synchronizer chain into one flop.
            line_meta <= line;
            line_s    <= line_meta;
            line_d    <= line_s;
        end
    end

    assign rise = line_s & ~line_d;
    assign fall = ~line_s & line_d;

    // Run-length counter. It holds how many cycles line_s kept its level before the current cycle.
    // At a falling edge, that value is the width of the high pulse that just ended.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
        end else if (rise || fall) begin
            counter <= CW'(1);
        end else if (counter != RST_W) begin
            counter <= counter + CW'(1);
        end
    end

    // low_done fires once, in the cycle that completes RST_CYC low cycles. The counter then saturates.
    assign low_done     = ~line_s & ~fall & (counter == RST_M1_W);
    // high_timeout fires when the current high cycle is already beyond MAX_CYC.
    assign high_timeout = line_s & ~rise & (counter >= MAX_W);
    assign width_ok     = (counter >= MIN_W) && (counter <= MAX_W);
    assign bit_val      = (counter >= THR_W);

    // FSM next-state logic. It also computes the word assembly and the one-cycle output pulses.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_nx     = state;
        bit_count_nx = bit_count;
        shift_nx     = shift_reg;
        data_nx      = data;
        word_seen_nx = word_seen;
        valid_nx     = 1'b0;
        error_nx     = 1'b0;
        frame_end_nx = 1'b0;

        case (state)
            WAIT_RESET: begin
                if (low_done) begin
                    state_nx     = IDLE;
                    bit_count_nx = '0;
                end
            end

            IDLE: begin
                if (rise) begin
                    state_nx = HIGH;
                end
            end

            HIGH: begin
                if (fall) begin
                    if (!width_ok) begin
                        error_nx     = 1'b1;
                        bit_count_nx = '0;
                        state_nx     = WAIT_RESET;
                    end else begin
                        shift_nx = {bit_val, shift_reg[DATA_WIDTH-1:1]};
                        state_nx = LOW;
                        if (bit_count == LAST_W) begin
                            data_nx      = shift_nx;
                            valid_nx     = 1'b1;
                            bit_count_nx = '0;
                            word_seen_nx = 1'b1;
                        end else begin
                            bit_count_nx = bit_count + BW'(1);
                        end
                    end
                end else if (high_timeout) begin
                    // Report the error immediately; do not wait for the line to fall.
                    error_nx     = 1'b1;
                    bit_count_nx = '0;
                    state_nx     = WAIT_RESET;
                end
            end

            LOW: begin
                if (rise) begin
                    state_nx = HIGH;
                end else if (low_done) begin
                    if (bit_count == '0) begin
                        if (word_seen) begin
                            frame_end_nx = 1'b1;
                            word_seen_nx = 1'b0;
                        end
                    end else begin
                        // Partial word: the long low has already resynchronized us.
                        error_nx     = 1'b1;
                        bit_count_nx = '0;
                    end
                    state_nx = IDLE;
                end
            end

            default: state_nx = WAIT_RESET;
        endcase
    end

    // State, word assembly and registered output pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= WAIT_RESET;
            bit_count <= '0;
            // NOTE: shift_reg is reset even though each word overwrites it fully, so no X value can ever reach data.
            shift_reg <= '0;
            data      <= '0;
            word_seen <= 1'b0;
            valid     <= 1'b0;
            error     <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_count <= bit_count_nx;
            shift_reg <= shift_nx;
            data      <= data_nx;
            word_seen <= word_seen_nx;
            valid     <= valid_nx;
            error     <= error_nx;
            frame_end <= frame_end_nx;
        end
    end

    assign synced = (state != WAIT_RESET);

endmodule

// File: tb/tb_unipolar_rz_decoder.sv
// Self-checking bench for unipolar_rz_decoder.
// A run-length model predicts every output on every cycle.
// Literal per-scenario checks pin the decoded words and the pulse counts.
module tb_unipolar_rz_decoder;

    localparam int DW    = 24;
    localparam int MIN_C = 5;
    localparam int THR_C = 30;
    localparam int MAX_C = 75;
    localparam int RST_C = 2500;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          line    = 1'b0;
    logic [DW-1:0] data;
    logic          valid, frame_end, error, synced;

    unipolar_rz_decoder dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .line     (line),
        .data     (data),
        .valid    (valid),
        .frame_end(frame_end),
        .error    (error),
        .synced   (synced)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: it works on the line as seen after two cycles of synchronizer delay.
    // It tracks the length of the current level run. At each fall it classifies the finished high run.
    // ------------------------------------------------------------------
    typedef enum {M_WAIT, M_IDLE, M_HIGH, M_LOW} mode_t;

    mode_t         m_mode;
    bit            m_q[$];
    bit            m_level;
    int            m_run;
    int            m_nbits;
    logic [DW-1:0] m_word, m_data;
    bit            m_seen, m_valid, m_err, m_fe;

    task automatic model_reset();
        m_q.delete();
        m_q.push_back(1'b0);
        m_q.push_back(1'b0);
        m_level = 1'b0;
        m_run   = 0;
        m_mode  = M_WAIT;
        m_nbits = 0;
        m_word  = '0;
        m_data  = '0;
        m_seen  = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_fe    = 1'b0;
    endtask

    task automatic model_step(input logic ln);
        bit cur, rise, fall;
        int w;
        cur = m_q.pop_front();
        m_q.push_back(ln);
        rise = 1'b0;
        fall = 1'b0;
        w    = 0;
        if (cur != m_level) begin
            w       = m_run;
            m_level = cur;
            m_run   = 1;
            rise    = cur;
            fall    = !cur;
        end else begin
            m_run++;
        end
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_fe    = 1'b0;
        case (m_mode)
            M_WAIT: if (!cur && m_run == RST_C) begin
                m_mode  = M_IDLE;
                m_nbits = 0;
            end
            M_IDLE: if (rise) m_mode = M_HIGH;
            M_HIGH: begin
                if (fall) begin
                    if (w < MIN_C || w > MAX_C) begin
                        m_err   = 1'b1;
                        m_nbits = 0;
                        m_mode  = M_WAIT;
                    end else begin
                        m_word[m_nbits] = (w >= THR_C);
                        m_nbits++;
                        m_mode = M_LOW;
                        if (m_nbits == DW) begin
                            m_data  = m_word;
                            m_valid = 1'b1;
                            m_nbits = 0;
                            m_seen  = 1'b1;
                        end
                    end
                end else if (cur && m_run > MAX_C) begin
                    m_err   = 1'b1;
                    m_nbits = 0;
                    m_mode  = M_WAIT;
                end
            end
            M_LOW: begin
                if (rise) begin
                    m_mode = M_HIGH;
                end else if (!cur && m_run == RST_C) begin
                    if (m_nbits == 0) begin
                        if (m_seen) begin
                            m_fe   = 1'b1;
                            m_seen = 1'b0;
                        end
                    end else begin
                        m_err   = 1'b1;
                        m_nbits = 0;
                    end
                    m_mode = M_IDLE;
                end
            end
            default: m_mode = M_WAIT;
        endcase
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step(line);
    end

    // Per-cycle comparison against the model, plus a record of observed DUT pulses.
    logic [DW-1:0] got_q[$];
    int            n_err = 0;
    int            n_fe  = 0;

    always @(negedge clock) begin
        if (reset_n) begin
            check("cycle_outputs", {data, valid, frame_end, error, synced},
                  {m_data, m_valid, m_fe, m_err, (m_mode != M_WAIT)});
            check("valid_error_exclusive", {valid, error} == 2'b11, 1'b0);
            if (valid)     got_q.push_back(data);
            if (error)     n_err++;
            if (frame_end) n_fe++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus. Line changes are made at the negative clock edge.
    // ------------------------------------------------------------------
    task automatic hold(input logic lvl, input int n);
        line = lvl;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            hold(1'b1, 40);
            hold(1'b0, 22);
        end else begin
            hold(1'b1, 20);
            hold(1'b0, 42);
        end
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int from, input int to);
        for (int i = from; i <= to; i++) send_bit(w[i]);
    endtask

    task automatic seg_start();
        got_q.delete();
        n_err = 0;
        n_fe  = 0;
    endtask

    initial begin
        #1 check("reset_outputs", {data, valid, frame_end, error, synced}, 28'h0);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;

        // Scenario 1: initial reset low, then one word.
        seg_start();
        hold(1'b0, 2600);
        check("t1_synced", synced, 1'b1);
        send_bits(24'hA5C3F0, 0, 23);
        hold(1'b0, 2600);
        check("t1_valid_count", got_q.size(), 1);
        check("t1_data", got_q[0], 24'hA5C3F0);
        check("t1_frame_end_count", n_fe, 1);
        check("t1_error_count", n_err, 0);

        // Scenario 2: back-to-back words with no gap.
        seg_start();
        send_bits(24'h000001, 0, 23);
        send_bits(24'hFFFFFF, 0, 23);
        hold(1'b0, 2600);
        check("t2_valid_count", got_q.size(), 2);
        check("t2_data0", got_q[0], 24'h000001);
        check("t2_data1", got_q[1], 24'hFFFFFF);
        check("t2_frame_end_count", n_fe, 1);
        check("t2_error_count", n_err, 0);

        // Scenario 3: a glitch in mid-word forces a resync.
        seg_start();
        send_bits(24'h3C3C3C, 0, 9);
        hold(1'b1, 3);
        hold(1'b0, 20);
        check("t3_error_at_glitch", n_err, 1);
        check("t3_unsynced", synced, 1'b0);
        send_bits(24'h3C3C3C, 10, 23);
        hold(1'b0, 2600);
        check("t3_no_valid", got_q.size(), 0);
        check("t3_resynced", synced, 1'b1);
        send_bits(24'h5A5A5A, 0, 23);
        hold(1'b0, 2600);
        check("t3_valid_count", got_q.size(), 1);
        check("t3_data", got_q[0], 24'h5A5A5A);
        check("t3_error_count", n_err, 1);
        check("t3_frame_end_count", n_fe, 1);

        // Scenario 4: a truncated word ended by a long low.
        seg_start();
        send_bits(24'hABCDEF, 0, 11);
        hold(1'b0, 2600);
        check("t4_error_count", n_err, 1);
        check("t4_synced", synced, 1'b1);
        check("t4_no_valid", got_q.size(), 0);
        check("t4_no_frame_end", n_fe, 0);
        send_bits(24'h0F0F0F, 0, 23);
        hold(1'b0, 2600);
        check("t4_valid_count", got_q.size(), 1);
        check("t4_data", got_q[0], 24'h0F0F0F);
        check("t4_frame_end_count", n_fe, 1);

        // Scenario 5: the line is stuck high while synced.
        seg_start();
        hold(1'b1, 100);
        check("t5_error_once", n_err, 1);
        check("t5_unsynced", synced, 1'b0);
        hold(1'b0, 2600);
        check("t5_error_still_once", n_err, 1);
        check("t5_resynced", synced, 1'b1);
        check("t5_no_valid", got_q.size(), 0);
        check("t5_no_frame_end", n_fe, 0);

        // Scenario 6: an asynchronous reset in the middle of bit 7.
        seg_start();
        send_bits(24'hFEDCBA, 0, 6);
        hold(1'b1, 10);
        #2 reset_n = 1'b0;
        #1 check("t6_async_reset_outputs", {data, valid, frame_end, error, synced}, 28'h0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        hold(1'b1, 10);
        hold(1'b0, 42);
        send_bits(24'hFEDCBA, 8, 23);
        hold(1'b0, 2600);
        check("t6_no_valid", got_q.size(), 0);
        check("t6_no_error", n_err, 0);
        check("t6_resynced", synced, 1'b1);
        send_bits(24'h123456, 0, 23);
        hold(1'b0, 2600);
        check("t6_valid_count", got_q.size(), 1);
        check("t6_data", got_q[0], 24'h123456);
        check("t6_frame_end_count", n_fe, 1);
        check("t6_error_count", n_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/unipolar_rz_decoder.md
Name: unipolar_rz_decoder

Overview:
- Receive-side counterpart of the unipolar RZ line encoder. Samples an asynchronous RZ line, measures each high pulse, classifies it as 0 or 1, and assembles DATA_WIDTH-bit words LSB-first.
- Detects the inter-frame reset (long low) and flags malformed traffic.
- Used for loopback verification of the encoder and for decoding upstream LED-chain traffic.

Parameters:
- DATA_WIDTH, 24: bits per word.
- CLOCK_RATE, 50e6: clock frequency in Hz (real).
- MIN_HIGH_TIME, 0.1e-6: high pulses shorter than this are glitches (real, seconds).
- THRESHOLD_TIME, 0.6e-6: high width at or above this decodes as 1, below as 0 (real, seconds).
- MAX_HIGH_TIME, 1.5e-6: high pulses longer than this are errors (real, seconds).
- RESET_TIME, 50e-6: low time that ends a frame (real, seconds).
- Derived cycle counts are int'(CLOCK_RATE*time), computed the same way as the encoder. Defaults give MIN=5, THR=30, MAX=75, RST=2500.
- The counter width is $clog2(RST+2).

Ports:
- clock  input  1  single system clock.
- reset_n  input  1  asynchronous, active-low reset.
- line  input  1  asynchronous RZ line.
- data  output  DATA_WIDTH  last complete word; held until the next word completes.
- valid  output  1  one-cycle pulse; data is new this cycle.
- frame_end  output  1  one-cycle pulse on reset detection after at least one word.
- error  output  1  one-cycle pulse on a protocol violation.
- synced  output  1  high while the decoder is in frame (not waiting for reset).

Behaviour:
- Reset (reset_n low, asynchronous):
  - Synchronizer flops are set to 0.
  - Outputs: data=0, valid=0, frame_end=0, error=0, synced=0.
  - Counter=0, bit_count=0, word_seen=0, state=WAIT_RESET.
- Input path: 2-flop synchronizer feeds line_s; line_d is line_s delayed by one cycle. A rising edge is line_s&!line_d; a falling edge is !line_s&line_d.
- Counter: counts consecutive cycles of the current line_s level. It is cleared to 1 on each edge and saturates at RST (never wraps).
- WAIT_RESET (synced=0):
  - Ignores all pulses.
  - When line_s has been low for RST cycles, go to IDLE with bit_count=0.
  - A rising edge restarts the wait.
- IDLE (synced=1):
  - Rising edge → HIGH.
  - Low saturating at RST → stay in IDLE, no pulse.
- HIGH: on a falling edge the measured width w is classified.
  - w<MIN or w>MAX: error pulse, discard the partial word, → WAIT_RESET.
  - Otherwise: bit = (w>=THR). shift_reg <= {bit, shift_reg[DATA_WIDTH-1:1]} (first received bit ends at data[0]), bit_count++, → LOW.
  - If bit_count reaches DATA_WIDTH: data<=assembled word, valid pulse, bit_count<=0, word_seen<=1.
  - If the counter exceeds MAX while still high: error immediately, → WAIT_RESET (do not wait for the fall).
- LOW:
  - Rising edge → HIGH. Back-to-back words carry no gap.
  - Low reaching RST with bit_count==0 and word_seen: frame_end pulse, word_seen<=0, → IDLE.
  - Low reaching RST with bit_count!=0: error pulse, discard the partial word, → IDLE (already synced by this reset).
- Latency: valid/error is registered. It asserts on the 3rd rising clock edge after the first edge that samples line low at the end of the final bit (2 sync + 1 output).
- valid and error are never high together.
- frame_end and valid cannot coincide, because frame_end requires RST low cycles.
- There is no backpressure; the consumer must accept valid every time it pulses.
- Reset asserted mid-word: everything clears immediately. After release, the decoder must see a full RST low before decoding.
- Line stuck high after reset: stays in WAIT_RESET with no error, synced=0.

Test Plan:
1. Release reset with line low for 2500 cycles, then send a 24-bit word 0xA5C3F0. Each bit is 0 = 20 high/42 low cycles or 1 = 40 high/22 low cycles, LSB first. Hold 2600 low. → synced=1 after 2500+2 cycles; a single valid with data=0xA5C3F0; frame_end one pulse 2500 low cycles after the last fall; error never.
2. Send two back-to-back words 0x000001 and 0xFFFFFF with no gap, then reset low. → two valid pulses in order with the correct data, exactly one frame_end.
3. Send 10 good bits, a 3-cycle high glitch, then 14 good bits. → error pulse at the glitch fall, synced=0, no valid until a 2500-cycle low is seen. After that, a clean word decodes correctly.
4. Send 12 bits, then line low for 2500 cycles. → error pulse when the low hits 2500, no valid, synced stays 1; the next full word decodes.
5. Drive line high for 100 cycles while synced. → error exactly once (counter passes 75), → WAIT_RESET; no further error while high persists.
6. Assert reset_n low for 1 cycle mid-word (bit 7). → all outputs 0 asynchronously; after release the remaining pulses are ignored until a 2500-cycle low, and no valid results from the interrupted word.
